obstacle_maneuver_fsm: RTL and testbench
========================================

Name: obstacle_maneuver_fsm

Overview:
- Drive-level sequencer for the RC car.
- Runs FORWARD while the path is clear. On an obstacle it performs a timed STOP -> REVERSE -> TURN maneuver, then resumes.
- Sits directly upstream of the 100 ms timer block: issues its start pulse and consumes its expired pulse. Phase durations are counted in whole timer periods.
- Drives the left/right motor direction commands consumed by the PWM/H-bridge stage.

Parameters:
- STOP_TICKS, 2, timer periods spent in STOP (1..255).
- REVERSE_TICKS, 5, timer periods spent in REVERSE (1..255).
- TURN_TICKS, 4, timer periods spent in TURN (1..255).
- MAX_RETRIES, 3, consecutive maneuvers with obstacle still present before FAULT (1..15).

Ports:
- clk  in  1  system clock (125 MHz).
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  level; 1 = autonomous drive allowed.
- obstacle  in  1  asynchronous level from range sensor; 1 = obstacle ahead.
- timer_expired  in  1  one-cycle pulse from timer.
- timer_start  out  1  one-cycle pulse to timer.
- motor_left  out  2  00 stop, 01 forward, 10 reverse; 11 never driven.
- motor_right  out  2  same encoding as motor_left.
- state_out  out  3  current state code.
- maneuver_count  out  8  total maneuvers started, saturating at 255.
- fault  out  1  1 while in FAULT.

Behaviour:
- Reset values: all outputs 0; state IDLE; tick_cnt 0; retry_cnt 0; turn_dir 0; synchronizer flops 0.
- obstacle passes through a 2-flop synchronizer (obs_s). A change on obstacle is visible at obs_s 2 cycles later.
- Transitions act on obs_s the following edge.
- State codes: IDLE=0, FORWARD=1, STOP=2, REVERSE=3, TURN=4, FAULT=5.
- All outputs are registered and update on the same edge as the state register.
- Motor commands by state:
  - IDLE, STOP, FAULT: both 00.
  - FORWARD: both 01.
  - REVERSE: both 10.
  - TURN with turn_dir=0: left 01, right 10.
  - TURN with turn_dir=1: left 10, right 01.
- IDLE -> FORWARD when enable=1.
- FORWARD -> STOP when obs_s=1. On this transition maneuver_count increments (saturating) and retry_cnt increments.
- Timed states are STOP, REVERSE and TURN.
  - On entry: tick_cnt cleared; timer_start=1 for exactly the first cycle in the state.
  - Each timer_expired in the state: tick_cnt+1.
  - If tick_cnt+1 == phase TICKS, take the exit transition on that edge.
  - Otherwise pulse timer_start on the next cycle.
- STOP exits to REVERSE.
- REVERSE exits to TURN. obs_s is ignored during STOP and REVERSE.
- TURN exit:
  - turn_dir toggles.
  - obs_s=0 -> FORWARD, retry_cnt cleared.
  - obs_s=1 and retry_cnt < MAX_RETRIES -> STOP; maneuver_count and retry_cnt increment.
  - obs_s=1 and retry_cnt == MAX_RETRIES -> FAULT.
- FAULT: motors 00, fault=1. Exits only to IDLE on enable=0; retry_cnt cleared.
- enable=0 in any state -> IDLE next edge; motors 00; no further timer_start. tick_cnt, retry_cnt and turn_dir are cleared, except that maneuver_count holds.
- timer_expired outside a timed state, or in the cycle timer_start is high, is ignored.
- The timer ignores start while running. The block never pulses timer_start before the expired pulse of the previous period.
- Simultaneous events:
  - enable=0 with timer_expired: enable wins.
  - obs_s=1 on the edge FORWARD is entered: STOP on the next edge.
- Asynchronous reset mid-maneuver: immediate return to reset values; motors 00 without waiting for a clock edge.

Test Plan:
- Bench setup: STOP_TICKS=2, REVERSE_TICKS=3, TURN_TICKS=2, MAX_RETRIES=3. Timer model has a 10-cycle period and expired pulses 10 cycles after start.
- Reset release, enable=1, obstacle=0 -> state_out=1, motors 01/01 one cycle after enable; timer_start never pulses.
- obstacle rises in FORWARD:
  - state_out=2 exactly 3 edges later; motors 00/00; timer_start pulse.
  - Exactly 2 expired later: REVERSE, motors 10/10.
  - 3 expired later: TURN, left 01, right 10.
  - 2 expired later with obstacle=0: FORWARD.
  - maneuver_count=1.
- Obstacle held high continuously -> 3 full maneuvers with TURN direction alternating 01/10, 10/01, 01/10. FAULT (fault=1, motors 00) at the third TURN exit. maneuver_count=3.
- enable dropped mid-REVERSE, coinciding with timer_expired -> IDLE next edge, motors 00, no timer_start afterwards. Re-enable -> FORWARD with maneuver_count held.
- Stray timer_expired pulses in IDLE and FORWARD -> no state change, no timer_start.
- Async reset asserted mid-TURN between clock edges -> motors 00 and state_out=0 before the next edge. maneuver_count=0 after release.

Source files
------------

// File: rtl/obstacle_maneuver_fsm.sv
// Drive-level sequencer: FORWARD while clear, timed STOP/REVERSE/TURN on obstacle,
// FAULT after too many consecutive blocked maneuvers. Phases are timed in timer periods.
module obstacle_maneuver_fsm #(
  parameter int unsigned STOP_TICKS    = 2,
  parameter int unsigned REVERSE_TICKS = 5,
  parameter int unsigned TURN_TICKS    = 4,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       obstacle,
  input  logic       timer_expired,
  output logic       timer_start,
  output logic [1:0] motor_left,
  output logic [1:0] motor_right,
  output logic [2:0] state_out,
  output logic [7:0] maneuver_count,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FORWARD = 3'd1,
    S_STOP    = 3'd2,
    S_REVERSE = 3'd3,
    S_TURN    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b01;
  localparam logic [1:0] M_REV  = 2'b10;

  localparam logic [7:0] STOP_T = 8'(STOP_TICKS);
  localparam logic [7:0] REV_T  = 8'(REVERSE_TICKS);
  localparam logic [7:0] TURN_T = 8'(TURN_TICKS);
  localparam logic [3:0] MAX_R  = 4'(MAX_RETRIES);

  state_t     r_state, w_state_nx;
  logic       r_sync1, r_obs_s;
  logic [7:0] r_tick, w_tick_nx;
  logic [3:0] r_retry, w_retry_nx;
  logic       r_dir, w_dir_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic       r_timer_start, w_start_nx;
  logic [1:0] r_motor_l, r_motor_r, w_ml_nx, w_mr_nx;
  logic       r_fault;
  logic       w_exp;
  logic [7:0] w_tick_inc;
  logic [7:0] w_cnt_inc;

  // An expiry landing in the same cycle as our own start pulse belongs to no period of ours.
  assign w_exp      = timer_expired & ~r_timer_start;
  assign w_tick_inc = r_tick + 8'd1;
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_comb begin
    w_state_nx = r_state;
    w_tick_nx  = r_tick;
    w_retry_nx = r_retry;
    w_dir_nx   = r_dir;
    w_cnt_nx   = r_cnt;
    w_start_nx = 1'b0;
    if (!enable) begin
      w_state_nx = S_IDLE;
      w_tick_nx  = 8'd0;
      w_retry_nx = 4'd0;
      w_dir_nx   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = S_FORWARD;
        S_FORWARD: begin
          if (r_obs_s) begin
            w_state_nx = S_STOP;
            w_tick_nx  = 8'd0;
            w_start_nx = 1'b1;
            w_cnt_nx   = w_cnt_inc;
            w_retry_nx = r_retry + 4'd1;
          end
        end
        S_STOP, S_REVERSE: begin
          if (w_exp) begin
            w_start_nx = 1'b1;
            if (w_tick_inc == ((r_state == S_STOP) ? STOP_T : REV_T)) begin
              w_state_nx = (r_state == S_STOP) ? S_REVERSE : S_TURN;
              w_tick_nx  = 8'd0;
            end else begin
              w_tick_nx  = w_tick_inc;
            end
          end
        end
        S_TURN: begin
          if (w_exp) begin
            if (w_tick_inc == TURN_T) begin
              w_tick_nx = 8'd0;
              w_dir_nx  = ~r_dir;
              if (!r_obs_s) begin
                w_state_nx = S_FORWARD;
                w_retry_nx = 4'd0;
              end else if (r_retry < MAX_R) begin
                w_state_nx = S_STOP;
                w_start_nx = 1'b1;
                w_cnt_nx   = w_cnt_inc;
                w_retry_nx = r_retry + 4'd1;
              end else begin
                w_state_nx = S_FAULT;
              end
            end else begin
              w_tick_nx  = w_tick_inc;
              w_start_nx = 1'b1;
            end
          end
        end
        S_FAULT: w_state_nx = S_FAULT;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Motor commands follow the next state so they register alongside it.
  always_comb begin
    w_ml_nx = M_STOP;
    w_mr_nx = M_STOP;
    case (w_state_nx)
      S_FORWARD: begin
        w_ml_nx = M_FWD;
        w_mr_nx = M_FWD;
      end
      S_REVERSE: begin
        w_ml_nx = M_REV;
        w_mr_nx = M_REV;
      end
      S_TURN: begin
        w_ml_nx = w_dir_nx ? M_REV : M_FWD;
        w_mr_nx = w_dir_nx ? M_FWD : M_REV;
      end
      default: begin
        w_ml_nx = M_STOP;
        w_mr_nx = M_STOP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1       <= 1'b0;
      r_obs_s       <= 1'b0;
      r_state       <= S_IDLE;
      r_tick        <= 8'd0;
      r_retry       <= 4'd0;
      r_dir         <= 1'b0;
      r_cnt         <= 8'd0;
      r_timer_start <= 1'b0;
      r_motor_l     <= M_STOP;
      r_motor_r     <= M_STOP;
      r_fault       <= 1'b0;
    end else begin
      r_sync1       <= obstacle;
      r_obs_s       <= r_sync1;
      r_state       <= w_state_nx;
      r_tick        <= w_tick_nx;
      r_retry       <= w_retry_nx;
      r_dir         <= w_dir_nx;
      r_cnt         <= w_cnt_nx;
      r_timer_start <= w_start_nx;
      r_motor_l     <= w_ml_nx;
      r_motor_r     <= w_mr_nx;
      r_fault       <= (w_state_nx == S_FAULT);
    end
  end

  assign timer_start    = r_timer_start;
  assign motor_left     = r_motor_l;
  assign motor_right    = r_motor_r;
  assign state_out      = r_state;
  assign maneuver_count = r_cnt;
  assign fault          = r_fault;

endmodule

// File: tb/tb_obstacle_maneuver_fsm.sv
// Directed bench for obstacle_maneuver_fsm with a 10-cycle behavioural timer model.
module tb_obstacle_maneuver_fsm;

  logic       clk = 1'b0;
  logic       reset, enable, obstacle, timer_expired, timer_start, fault;
  logic [1:0] motor_left, motor_right;
  logic [2:0] state_out;
  logic [7:0] maneuver_count;

  logic t_run, t_exp, stray;
  int   t_cnt;
  int   n_start = 0;
  int   n_exp = 0;
  int   total = 0;
  int   bad = 0;
  int   snap;

  always #5 clk = ~clk;

  obstacle_maneuver_fsm #(
    .STOP_TICKS(2), .REVERSE_TICKS(3), .TURN_TICKS(2), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .obstacle(obstacle),
    .timer_expired(timer_expired), .timer_start(timer_start),
    .motor_left(motor_left), .motor_right(motor_right), .state_out(state_out),
    .maneuver_count(maneuver_count), .fault(fault)
  );

  // Timer: a start seen while idle yields one expired pulse ten cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_run <= 1'b0;
      t_cnt <= 0;
      t_exp <= 1'b0;
    end else begin
      t_exp <= 1'b0;
      if (t_run) begin
        if (t_cnt == 9) begin
          t_exp <= 1'b1;
          t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt + 1;
        end
      end else if (timer_start) begin
        t_run <= 1'b1;
        t_cnt <= 0;
      end
    end
  end

  assign timer_expired = t_exp | stray;

  always @(posedge clk) begin
    if (timer_start)   n_start <= n_start + 1;
    if (timer_expired) n_exp   <= n_exp + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int k = 0; k < budget && state_out !== s; k++) tick();
    chk({5'd0, state_out}, {5'd0, s}, tag);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; obstacle = 1'b0; stray = 1'b0;
    #1;
    chk({5'd0, state_out}, 8'd0, "rst_state");
    chk({6'd0, motor_left}, 8'd0, "rst_ml");
    chk({6'd0, motor_right}, 8'd0, "rst_mr");
    chk(maneuver_count, 8'd0, "rst_cnt");
    chk({7'd0, fault}, 8'd0, "rst_fault");
    chk({7'd0, timer_start}, 8'd0, "rst_tstart");
    tick(); tick();
    reset = 1'b1;
    tick();

    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk({5'd0, state_out}, 8'd0, "stray_idle_state");
    chk({7'd0, timer_start}, 8'd0, "stray_idle_tstart");

    enable = 1'b1;
    tick();
    chk({5'd0, state_out}, 8'd1, "fwd_state");
    chk({motor_left, motor_right, 4'd0}, 8'h50, "fwd_motors");
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick(); tick();
    chk({5'd0, state_out}, 8'd1, "stray_fwd_state");
    chk(8'(n_start), 8'd0, "fwd_no_tstart");

    obstacle = 1'b1;
    tick(); tick();
    chk({5'd0, state_out}, 8'd1, "obs_lat_hold");
    tick();
    chk({5'd0, state_out}, 8'd2, "obs_lat_stop");
    chk({motor_left, motor_right, 4'd0}, 8'h00, "stop_motors");
    chk({7'd0, timer_start}, 8'd1, "stop_tstart");
    chk(maneuver_count, 8'd1, "stop_cnt1");
    snap = n_exp;
    wait_state(3'd3, 100, "to_reverse");
    chk(8'(n_exp - snap), 8'd2, "stop_ticks");
    chk({motor_left, motor_right, 4'd0}, 8'hA0, "rev_motors");
    snap = n_exp;
    wait_state(3'd4, 100, "to_turn");
    chk(8'(n_exp - snap), 8'd3, "rev_ticks");
    chk({motor_left, motor_right, 4'd0}, 8'h60, "turn0_motors");
    obstacle = 1'b0;
    snap = n_exp;
    wait_state(3'd1, 100, "turn_to_fwd");
    chk(8'(n_exp - snap), 8'd2, "turn_ticks");
    chk(maneuver_count, 8'd1, "cnt_after_one");

    // fresh start so the retry run begins with turn_dir=0 and count=0
    @(negedge clk); reset = 1'b0; obstacle = 1'b1;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_state(3'd2, 100, "retry_stop");
      chk(maneuver_count, 8'(i + 1), "retry_cnt");
      wait_state(3'd3, 100, "retry_rev");
      wait_state(3'd4, 100, "retry_turn");
      chk({motor_left, motor_right, 4'd0}, (i == 1) ? 8'h90 : 8'h60, "retry_turn_dir");
    end
    wait_state(3'd5, 100, "to_fault");
    chk({7'd0, fault}, 8'd1, "fault_flag");
    chk({motor_left, motor_right, 4'd0}, 8'h00, "fault_motors");
    chk(maneuver_count, 8'd3, "fault_cnt");
    for (int k = 0; k < 30; k++) tick();
    chk({5'd0, state_out}, 8'd5, "fault_sticky");

    enable = 1'b0;
    tick();
    chk({5'd0, state_out}, 8'd0, "fault_to_idle");
    chk({7'd0, fault}, 8'd0, "idle_fault_clr");
    enable = 1'b1;
    tick();
    chk({5'd0, state_out}, 8'd1, "reen_fwd");
    tick();
    chk({5'd0, state_out}, 8'd2, "reen_stop");
    chk(maneuver_count, 8'd4, "reen_cnt");
    wait_state(3'd3, 100, "drop_rev");
    for (int k = 0; k < 40 && timer_expired !== 1'b1; k++) tick();
    chk({7'd0, timer_expired}, 8'd1, "drop_exp_seen");
    enable = 1'b0;
    tick();
    chk({5'd0, state_out}, 8'd0, "drop_idle");
    chk({motor_left, motor_right, 4'd0}, 8'h00, "drop_motors");
    chk({7'd0, timer_start}, 8'd0, "drop_tstart");
    obstacle = 1'b0;
    snap = n_start;
    for (int k = 0; k < 30; k++) tick();
    chk(8'(n_start - snap), 8'd0, "drop_no_tstart");
    enable = 1'b1;
    tick();
    chk({5'd0, state_out}, 8'd1, "drop_reen_fwd");
    chk(maneuver_count, 8'd4, "drop_cnt_held");

    obstacle = 1'b1;
    wait_state(3'd4, 200, "areset_turn");
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk({5'd0, state_out}, 8'd0, "areset_state");
    chk({motor_left, motor_right, 4'd0}, 8'h00, "areset_motors");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk(maneuver_count, 8'd0, "areset_cnt");
    chk({5'd0, state_out}, 8'd1, "areset_fwd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
